// File: rtl/cache_pkg.sv
// Shared cache-hierarchy constants and types for the L1->L2 miss path.
package cache_pkg;

    localparam int LINE_ADDR_W = 26;     // 32-bit byte address minus line offset
    localparam int OFFSET_BITS = 6;      // 64-byte lines
    localparam logic [3:0] TRACE_CLEAR = 4'd8;

    typedef logic [LINE_ADDR_W-1:0] line_addr_t;

endpackage

// File: rtl/miss_q_match.sv
// DEPTH-way comparator: flags a request line address that is already
// held by any valid queue entry.
module miss_q_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 26
) (
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DEPTH-1:0][ADDR_W-1:0]  entries,
    input  logic [DEPTH-1:0]              valid,
    output logic                          hit
);

    logic [DEPTH-1:0] eq;

    // One comparator per entry, gated by that entry's valid bit.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign eq[i] = valid[i] & (entries[i] == req_addr);
    end

    assign hit = |eq;

endmodule

// File: rtl/l2_miss_queue.sv
// L1->L2 miss queue: coalesces duplicate line fills, issues unique lines to
// L2 in FIFO order, and keeps saturating issue/merge statistics.
module l2_miss_queue
    import cache_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = LINE_ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       req_valid,
    input  logic [ADDR_W-1:0]          req_addr,
    output logic                       req_ready,
    output logic                       l2_valid,
    output logic [ADDR_W-1:0]          l2_addr,
    input  logic                       l2_ready,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           issued_cnt,
    output logic [CNT_W-1:0]           merged_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] entries;
    logic [DEPTH-1:0]             valid;
    logic [PTR_W-1:0]             rd_ptr;
    logic [PTR_W-1:0]             wr_ptr;

    logic hit;
    logic full;
    logic accept;
    logic push;
    logic merge;
    logic pop;

    // Match sees the mask as of the start of the cycle, so a head being
    // popped this cycle still absorbs a duplicate request.
    miss_q_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_match (
        .req_addr (req_addr),
        .entries  (entries),
        .valid    (valid),
        .hit      (hit)
    );

    // Readiness ignores l2_ready: a full queue never reuses the slot being
    // freed by a same-cycle pop.
    assign full      = (occupancy == OCC_W'(DEPTH));
    assign req_ready = hit | ~full;

    assign accept = req_valid & req_ready & ~clear;
    assign merge  = accept & hit;
    assign push   = accept & ~hit;

    assign l2_valid = (occupancy != '0);
    assign pop      = l2_valid & l2_ready & ~clear;

    // Stale entry contents are masked so the L2 side sees zero when empty.
    assign l2_addr = l2_valid ? entries[rd_ptr] : '0;

    // Entry storage, valid mask and pointers; clear flushes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries <= '0;
            valid   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else if (clear) begin
            valid  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            // Pop and push never target the same slot: a push needs a free
            // slot, a pop needs an occupied one, and wr_ptr != rd_ptr then.
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (push) begin
                entries[wr_ptr] <= req_addr;
                valid[wr_ptr]   <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
        end
    end

    // Occupancy is tracked explicitly so full and empty never rely on
    // pointer equality.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else if (clear) begin
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt <= '0;
            merged_cnt <= '0;
        end else if (clear) begin
            issued_cnt <= '0;
            merged_cnt <= '0;
        end else begin
            if (pop && issued_cnt != {CNT_W{1'b1}})
                issued_cnt <= issued_cnt + 1'b1;
            if (merge && merged_cnt != {CNT_W{1'b1}})
                merged_cnt <= merged_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_l2_miss_queue.sv
// Self-checking bench for l2_miss_queue: directed scenarios followed by
// random traffic, all checked every cycle against a queue-based model.
module tb_l2_miss_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 26;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              req_valid = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              req_ready;
    logic              l2_valid;
    logic [ADDR_W-1:0] l2_addr;
    logic              l2_ready = 1'b0;
    logic [2:0]        occupancy;
    logic [CNT_W-1:0]  issued_cnt;
    logic [CNT_W-1:0]  merged_cnt;

    l2_miss_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .l2_valid   (l2_valid),
        .l2_addr    (l2_addr),
        .l2_ready   (l2_ready),
        .occupancy  (occupancy),
        .issued_cnt (issued_cnt),
        .merged_cnt (merged_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: pending lines in issue order plus the two counters.
    logic [ADDR_W-1:0] mq[$];
    logic [CNT_W-1:0]  m_iss = '0;
    logic [CNT_W-1:0]  m_mrg = '0;

    function automatic bit m_hit(logic [ADDR_W-1:0] a);
        foreach (mq[i]) if (mq[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] x);
        return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("req_ready",  {31'd0, req_ready}, {31'd0, m_hit(req_addr) || mq.size() < DEPTH});
        chk("l2_valid",   {31'd0, l2_valid},  {31'd0, mq.size() != 0});
        chk("l2_addr",    {6'd0, l2_addr},    (mq.size() != 0) ? {6'd0, mq[0]} : 32'd0);
        chk("occupancy",  {29'd0, occupancy}, mq.size());
        chk("issued_cnt", issued_cnt, m_iss);
        chk("merged_cnt", merged_cnt, m_mrg);
    endtask

    // One clock: drive at the falling edge, check just after, advance the
    // model by the rules of the queue, then wait for the next falling edge.
    task automatic cyc(bit v, logic [ADDR_W-1:0] a, bit rdy, bit clr);
        bit hit, rdy_q, acc, pop;
        req_valid = v;
        req_addr  = a;
        l2_ready  = rdy;
        clear     = clr;
        #1;
        check_all();
        hit   = m_hit(a);
        rdy_q = hit || (mq.size() < DEPTH);
        acc   = v && rdy_q;
        pop   = (mq.size() != 0) && rdy;
        if (clr) begin
            mq.delete();
            m_iss = '0;
            m_mrg = '0;
        end else begin
            if (acc && hit) m_mrg = sat_inc(m_mrg);
            if (pop) begin
                void'(mq.pop_front());
                m_iss = sat_inc(m_iss);
            end
            if (acc && !hit) mq.push_back(a);
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        #1;
        check_all();
        chk("rst_occ", {29'd0, occupancy}, 32'd0);
        chk("rst_l2_valid", {31'd0, l2_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);

        // First push, then duplicate coalesced while pending
        cyc(1'b1, 26'hABC, 1'b0, 1'b0);
        chk("tp1_valid", {31'd0, l2_valid}, 32'd1);
        chk("tp1_addr",  {6'd0, l2_addr}, 32'hABC);
        chk("tp1_occ",   {29'd0, occupancy}, 32'd1);
        cyc(1'b1, 26'hABC, 1'b0, 1'b0);
        chk("tp2_occ",   {29'd0, occupancy}, 32'd1);
        chk("tp2_merged", merged_cnt, 32'd1);
        cyc(1'b0, 26'h0, 1'b1, 1'b0);
        chk("tp2_issued", issued_cnt, 32'd1);
        chk("tp2_empty", {31'd0, l2_valid}, 32'd0);

        // Fill to full, reject new line, merge pending line
        cyc(1'b0, 26'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) cyc(1'b1, ADDR_W'(i), 1'b0, 1'b0);
        chk("full_occ", {29'd0, occupancy}, 32'd4);
        req_addr = 26'h5;
        l2_ready = 1'b1;
        #1;
        chk("full_rdy_nomatch_pop", {31'd0, req_ready}, 32'd0);
        cyc(1'b1, 26'h5, 1'b0, 1'b0);
        cyc(1'b1, 26'h2, 1'b0, 1'b0);
        chk("full_merged", merged_cnt, 32'd1);
        chk("full_occ2", {29'd0, occupancy}, 32'd4);

        // Drain in order
        for (int i = 0; i < 6; i++) begin
            chk("drain_valid", {31'd0, l2_valid}, (i < 4) ? 32'd1 : 32'd0);
            chk("drain_addr",  {6'd0, l2_addr}, (i < 4) ? 32'(i + 1) : 32'd0);
            cyc(1'b0, 26'h0, 1'b1, 1'b0);
        end
        chk("drain_issued", issued_cnt, 32'd4);

        // clear beats push, pop and counting in the same cycle
        cyc(1'b1, 26'h20, 1'b0, 1'b0);
        cyc(1'b1, 26'h21, 1'b0, 1'b0);
        chk("clr_pre_occ", {29'd0, occupancy}, 32'd2);
        cyc(1'b1, 26'h7, 1'b1, 1'b1);
        chk("clr_occ",    {29'd0, occupancy}, 32'd0);
        chk("clr_valid",  {31'd0, l2_valid}, 32'd0);
        chk("clr_issued", issued_cnt, 32'd0);
        chk("clr_merged", merged_cnt, 32'd0);

        // Streaming with continuous l2_ready: pointers wrap, occupancy <= 1
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, ADDR_W'(32'h30 + i), 1'b1, 1'b0);
            chk("wrap_occ_le1", {31'd0, occupancy <= 3'd1}, 32'd1);
        end
        cyc(1'b0, 26'h0, 1'b1, 1'b0);
        chk("wrap_issued", issued_cnt, 32'd10);

        // Asynchronous reset mid-transfer drops state immediately
        cyc(1'b1, 26'h44, 1'b0, 1'b0);
        cyc(1'b1, 26'h45, 1'b1, 1'b0);
        l2_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        mq.delete();
        m_iss = '0;
        m_mrg = '0;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic over a small address space to exercise merging
        for (int n = 0; n < 500; n++) begin
            cyc(1'($urandom_range(0, 1)),
                ADDR_W'($urandom_range(0, 9)),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 59) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
